cgra_config_sequencer: RTL and testbench
========================================

# cgra_config_sequencer

Top-level run controller for the CGRA fabric. On a host `start` pulse it resets the bitstream configurator and clocks the configurator's serial bitstream into the fabric config chain. It then waits for the configurator's `done` and releases the fabric from reset for a host-specified number of execution cycles before reporting completion. A watchdog on the `done` wait and an `abort` input keep the fabric in a known state when configuration goes wrong.

## Interface
Parameters:
- `TOTAL_NUM_BITS`, 832: length of the config chain; must match the configurator.
- `DONE_TIMEOUT`, 16: maximum cycles in WAIT_DONE before ERROR.
- `RUN_W`, 32: width of the run-cycle count.

Ports (all outputs registered):
- `clock`  in  1  sole clock; all logic on posedge.
- `sync_reset_n`  in  1  one clock; reset is synchronous and active-low.
- `start`  in  1  host request; sampled only in IDLE, DONE or ERROR.
- `abort`  in  1  host abort; honoured in any busy state.
- `run_cycles`  in  RUN_W  execution length; latched on an accepted `start`.
- `busy`  out  1  high in CFG_RESET, LOAD, WAIT_DONE and RUN.
- `done`  out  1  run completed; held until the next accepted `start` or reset.
- `error`  out  1  watchdog expired; held until the next accepted `start` or reset.
- `cfg_sync_reset`  out  1  to the configurator's `sync_reset` (active-high).
- `cfg_enable`  out  1  to the configurator's `enable`.
- `cfg_bitstream`  in  1  from the configurator's `bitstream`.
- `cfg_done`  in  1  from the configurator's `done`.
- `fabric_config_enable`  out  1  shift enable of the fabric config chain.
- `fabric_bitstream`  out  1  serial config data into the fabric.
- `fabric_reset`  out  1  active-high fabric datapath reset.

## Operation
- States: IDLE, CFG_RESET, LOAD, WAIT_DONE, RUN, DONE, ERROR.
- Reset values:
  - state IDLE; `cfg_sync_reset`=1; `fabric_reset`=1.
  - `cfg_enable`=0, `fabric_config_enable`=0, `fabric_bitstream`=0.
  - `busy`=0, `done`=0, `error`=0; all counters 0.
- IDLE/DONE/ERROR + `start` → CFG_RESET.
  - Latch `run_cycles`; clear `done` and `error`.
  - `start` in any other state is ignored.
- CFG_RESET: exactly one cycle.
  - `cfg_sync_reset`=1, `fabric_reset`=1.
  - Next state LOAD with the issue counter at 0.
- LOAD:
  - `cfg_sync_reset`=0 and `cfg_enable`=1 for exactly TOTAL_NUM_BITS consecutive cycles; the issue counter counts 0..TOTAL_NUM_BITS-1.
  - On the last issue, go to WAIT_DONE.
- Forwarding:
  - `fabric_config_enable` is `cfg_enable` delayed by one register stage.
  - `fabric_bitstream` is `cfg_bitstream` registered, so enable and data stay aligned.
  - The fabric therefore sees exactly TOTAL_NUM_BITS enabled bits, first bit = configurator storage[0].
- WAIT_DONE:
  - `cfg_enable`=0; the watchdog counts cycles.
  - `cfg_done`=1 → RUN.
  - Watchdog reaching DONE_TIMEOUT without `cfg_done` → ERROR.
- RUN:
  - `fabric_reset`=0; the run counter counts up to the latched `run_cycles`, then → DONE.
  - A latched `run_cycles` of 0 goes WAIT_DONE → DONE directly; `fabric_reset` stays 1.
- DONE: `fabric_reset`=1, `done`=1.
- ERROR: `fabric_reset`=1, `error`=1.
- `abort` in any busy state → IDLE next cycle.
  - `cfg_enable`=0, `fabric_config_enable`=0, `fabric_reset`=1, `cfg_sync_reset`=1.
  - Partial configuration is discarded.
- Priority: reset > abort > start > normal transitions.
- Counter widths:
  - issue: $clog2(TOTAL_NUM_BITS+1).
  - watchdog: $clog2(DONE_TIMEOUT+1).
  - run: RUN_W, with no wrap (compare for equality before incrementing).

## Timing
- `start` at edge t0 → CFG_RESET during t0+1.
  - `cfg_enable` high t0+2 .. t0+1+TOTAL_NUM_BITS.
  - `fabric_config_enable` high t0+3 .. t0+2+TOTAL_NUM_BITS.
- The configurator raises `cfg_done` 2 cycles after its last enabled cycle; RUN begins the cycle after `cfg_done` is sampled.
- `fabric_reset` is low for exactly `run_cycles` cycles.
- `done` rises the cycle after the last run cycle.
- `busy` falls in the same cycle that `done` or `error` rises.
- A reset asserted mid-LOAD returns every output to its reset value at the next edge.

## Structure
- Shared package `cgra_ctrl_pkg`:
  - State enum `cgra_seq_state_t`.
  - Default constants `CGRA_CFG_BITS`=832 and `CGRA_DONE_TIMEOUT`=16.
- No sub-module: one FSM plus three inline counters.
- The top level instantiates `CGRA_configurator` beside this block.

## Test plan
- Nominal: TOTAL_NUM_BITS=832, `run_cycles`=10, with the real configurator.
  - `fabric_config_enable` high for exactly 832 cycles; captured bits equal configurator storage.
  - `fabric_reset` low for exactly 10 cycles; `done`=1 and `busy`=0 afterwards.
- Watchdog: TOTAL_NUM_BITS=8, `cfg_done` tied 0.
  - ERROR exactly 16 cycles after entering WAIT_DONE; `error`=1, `fabric_reset`=1.
  - A following `start` clears `error`.
- Zero run: `run_cycles`=0 → DONE with no cycle of `fabric_reset`=0.
- Abort after 100 LOAD cycles: next cycle state IDLE, `cfg_enable`=0, `cfg_sync_reset`=1. A fresh `start` then shifts all 832 bits.
- `start` pulsed during LOAD and RUN is ignored: exactly one configuration pass, one `done`.
- `sync_reset_n`=0 mid-RUN: the next cycle shows all outputs at reset values and state IDLE.

Source files
------------

// File: rtl/cgra_ctrl_pkg.sv
// Shared types and defaults for the CGRA run controller.
package cgra_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG_RESET,
    LOAD,
    WAIT_DONE,
    RUN,
    DONE,
    ERROR
  } cgra_seq_state_t;

  localparam int CGRA_CFG_BITS     = 832;
  localparam int CGRA_DONE_TIMEOUT = 16;

  function automatic logic is_busy(input cgra_seq_state_t s);
    return (s == CFG_RESET) || (s == LOAD) || (s == WAIT_DONE) || (s == RUN);
  endfunction

endpackage

// File: rtl/cgra_config_sequencer.sv
// Run controller: configures the fabric from the bitstream configurator, then
// releases the fabric from reset for a host-specified number of cycles.
module cgra_config_sequencer
  import cgra_ctrl_pkg::*;
#(
  parameter int TOTAL_NUM_BITS = CGRA_CFG_BITS,
  parameter int DONE_TIMEOUT   = CGRA_DONE_TIMEOUT,
  parameter int RUN_W          = 32
) (
  input  logic             clock,
  input  logic             sync_reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [RUN_W-1:0] run_cycles,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cfg_sync_reset,
  output logic             cfg_enable,
  input  logic             cfg_bitstream,
  input  logic             cfg_done,
  output logic             fabric_config_enable,
  output logic             fabric_bitstream,
  output logic             fabric_reset
);

  localparam int ISSUE_W = $clog2(TOTAL_NUM_BITS + 1);
  localparam int WD_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [ISSUE_W-1:0] ISSUE_LAST = ISSUE_W'(TOTAL_NUM_BITS - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(DONE_TIMEOUT - 1);

  cgra_seq_state_t    state, state_nxt;
  logic [ISSUE_W-1:0] issue_cnt, issue_cnt_nxt;
  logic [WD_W-1:0]    wd_cnt, wd_cnt_nxt;
  logic [RUN_W-1:0]   run_cnt, run_cnt_nxt;
  logic [RUN_W-1:0]   run_lat;
  logic               start_ok;
  logic               abort_ok;

  assign start_ok = start && (state inside {IDLE, DONE, ERROR});
  assign abort_ok = abort && is_busy(state);

  always_comb begin
    state_nxt     = state;
    issue_cnt_nxt = issue_cnt;
    wd_cnt_nxt    = wd_cnt;
    run_cnt_nxt   = run_cnt;
    if (abort_ok) begin
      state_nxt     = IDLE;
      issue_cnt_nxt = '0;
      wd_cnt_nxt    = '0;
      run_cnt_nxt   = '0;
    end else if (start_ok) begin
      state_nxt     = CFG_RESET;
      issue_cnt_nxt = '0;
      wd_cnt_nxt    = '0;
      run_cnt_nxt   = '0;
    end else begin
      case (state)
        CFG_RESET: begin
          state_nxt     = LOAD;
          issue_cnt_nxt = '0;
        end
        LOAD: begin
          if (issue_cnt == ISSUE_LAST) begin
            state_nxt  = WAIT_DONE;
            wd_cnt_nxt = '0;
          end else begin
            issue_cnt_nxt = issue_cnt + ISSUE_W'(1);
          end
        end
        WAIT_DONE: begin
          // cfg_done wins over a watchdog expiring in the same cycle
          if (cfg_done) begin
            if (run_lat == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt   = RUN;
              run_cnt_nxt = RUN_W'(1);
            end
          end else if (wd_cnt == WD_LAST) begin
            state_nxt = ERROR;
          end else begin
            wd_cnt_nxt = wd_cnt + WD_W'(1);
          end
        end
        RUN: begin
          // run_cnt holds the 1-based index of the current run cycle
          if (run_cnt == run_lat) state_nxt = DONE;
          else                    run_cnt_nxt = run_cnt + RUN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Stage p0: state, counters and outputs decoded from the next state
  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      state                <= IDLE;
      issue_cnt            <= '0;
      wd_cnt               <= '0;
      run_cnt              <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
      cfg_sync_reset       <= 1'b1;
      cfg_enable           <= 1'b0;
      fabric_reset         <= 1'b1;
      fabric_config_enable <= 1'b0;
      fabric_bitstream     <= 1'b0;
    end else begin
      state          <= state_nxt;
      issue_cnt      <= issue_cnt_nxt;
      wd_cnt         <= wd_cnt_nxt;
      run_cnt        <= run_cnt_nxt;
      busy           <= is_busy(state_nxt);
      done           <= (state_nxt == DONE);
      error          <= (state_nxt == ERROR);
      cfg_sync_reset <= (state_nxt == IDLE) || (state_nxt == CFG_RESET);
      cfg_enable     <= (state_nxt == LOAD);
      fabric_reset   <= (state_nxt != RUN);
      // Stage p1: forward configurator data one register behind its enable
      fabric_config_enable <= cfg_enable && !abort_ok;
      fabric_bitstream     <= cfg_bitstream;
    end
  end

  always_ff @(posedge clock) begin
    if (start_ok) run_lat <= run_cycles;
  end

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Bench for cgra_config_sequencer with a behavioural bitstream configurator.
module tb_cgra_config_sequencer;
  import cgra_ctrl_pkg::*;

  localparam int N  = 832;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        sync_reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] run_cycles = '0;
  logic        busy, done, error, cfg_sync_reset, cfg_enable;
  logic        cfg_bitstream, cfg_done;
  logic        fabric_config_enable, fabric_bitstream, fabric_reset;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cgra_config_sequencer #(
    .TOTAL_NUM_BITS(N),
    .DONE_TIMEOUT(TO),
    .RUN_W(32)
  ) dut (
    .clock(clock),
    .sync_reset_n(sync_reset_n),
    .start(start),
    .abort(abort),
    .run_cycles(run_cycles),
    .busy(busy),
    .done(done),
    .error(error),
    .cfg_sync_reset(cfg_sync_reset),
    .cfg_enable(cfg_enable),
    .cfg_bitstream(cfg_bitstream),
    .cfg_done(cfg_done),
    .fabric_config_enable(fabric_config_enable),
    .fabric_bitstream(fabric_bitstream),
    .fabric_reset(fabric_reset)
  );

  // Configurator model: presents storage[ptr] while enabled, done 2 cycles after last bit
  logic        storage [N];
  int unsigned cptr;
  logic        cdone_r;
  logic        block_done = 1'b0;

  assign cfg_bitstream = (cptr < N) ? storage[cptr] : 1'b0;
  assign cfg_done      = cdone_r & ~block_done;

  always @(posedge clock) begin
    if (cfg_sync_reset) begin
      cptr    <= 0;
      cdone_r <= 1'b0;
    end else begin
      if (cfg_enable && cptr < N) cptr <= cptr + 1;
      cdone_r <= (cptr == N);
    end
  end

  logic exp_q[$];
  logic obs_q[$];

  typedef struct packed {
    int   en_cnt;
    int   cfg_en_cnt;
    int   first_cfg_en;
    int   first_fab_en;
    int   rst_low;
    int   end_cyc;
    int   cfg_rst_busy;
    logic busy_end;
    logic rst_end;
    logic done_end;
    logic err_end;
    logic done_c1;
    logic err_c1;
    logic busy_c1;
  } meas_t;

  task automatic fill_storage();
    for (int i = 0; i < N; i++) storage[i] = 1'($urandom_range(0, 1));
  endtask

  // Leaves the bench at the negedge of cycle 1 (the CFG_RESET cycle)
  task automatic start_pass(input logic [31:0] r);
    for (int i = 0; i < N; i++) exp_q.push_back(storage[i]);
    run_cycles = r;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic observe(input int max_cyc, input int poke_a, input int poke_b, output meas_t m);
    m = '0;
    m.first_cfg_en = -1;
    m.first_fab_en = -1;
    m.end_cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c == 1) begin
        m.done_c1 = done;
        m.err_c1  = error;
        m.busy_c1 = busy;
      end
      if (cfg_enable) begin
        m.cfg_en_cnt++;
        if (m.first_cfg_en < 0) m.first_cfg_en = c;
      end
      if (fabric_config_enable) begin
        m.en_cnt++;
        if (m.first_fab_en < 0) m.first_fab_en = c;
        obs_q.push_back(fabric_bitstream);
      end
      if (!fabric_reset) m.rst_low++;
      if (busy && cfg_sync_reset) m.cfg_rst_busy++;
      if (done || error) begin
        m.end_cyc  = c;
        m.busy_end = busy;
        m.rst_end  = fabric_reset;
        m.done_end = done;
        m.err_end  = error;
        break;
      end
      start = (c == poke_a || c == poke_b);
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    sync_reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (cfg_sync_reset !== 1'b1) begin failures++; $display("FAIL reset_cfg_sync_reset got=%b exp=1", cfg_sync_reset); end
    checks++; if (cfg_enable !== 1'b0) begin failures++; $display("FAIL reset_cfg_enable got=%b exp=0", cfg_enable); end
    checks++; if (fabric_config_enable !== 1'b0) begin failures++; $display("FAIL reset_fab_en got=%b exp=0", fabric_config_enable); end
    checks++; if (fabric_bitstream !== 1'b0) begin failures++; $display("FAIL reset_fab_bit got=%b exp=0", fabric_bitstream); end
    checks++; if (fabric_reset !== 1'b1) begin failures++; $display("FAIL reset_fabric_reset got=%b exp=1", fabric_reset); end
    sync_reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0 || cfg_sync_reset !== 1'b1) begin failures++; $display("FAIL idle_after_reset got=busy%b/csr%b exp=busy0/csr1", busy, cfg_sync_reset); end
  endtask

  task automatic test_nominal();
    meas_t m;
    logic e, o;
    fill_storage();
    start_pass(32'd10);
    observe(N + 100, -1, -1, m);
    checks++; if (m.first_cfg_en !== 2) begin failures++; $display("FAIL nom_first_cfg_en got=%0d exp=2", m.first_cfg_en); end
    checks++; if (m.first_fab_en !== 3) begin failures++; $display("FAIL nom_first_fab_en got=%0d exp=3", m.first_fab_en); end
    checks++; if (m.cfg_en_cnt !== N) begin failures++; $display("FAIL nom_cfg_en_cnt got=%0d exp=%0d", m.cfg_en_cnt, N); end
    checks++; if (m.en_cnt !== N) begin failures++; $display("FAIL nom_fab_en_cnt got=%0d exp=%0d", m.en_cnt, N); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin failures++; $display("FAIL nom_bit got=%b exp=%b", o, e); end
    end
    obs_q.delete();
    checks++; if (m.rst_low !== 10) begin failures++; $display("FAIL nom_run_len got=%0d exp=10", m.rst_low); end
    checks++; if (m.end_cyc !== N + 14) begin failures++; $display("FAIL nom_done_cycle got=%0d exp=%0d", m.end_cyc, N + 14); end
    checks++; if (m.done_end !== 1'b1 || m.busy_end !== 1'b0) begin failures++; $display("FAIL nom_done_busy got=d%b/b%b exp=d1/b0", m.done_end, m.busy_end); end
    repeat (3) @(negedge clock);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || fabric_reset !== 1'b1) begin failures++; $display("FAIL nom_done_held got=d%b/b%b/r%b exp=d1/b0/r1", done, busy, fabric_reset); end
  endtask

  task automatic test_zero_run();
    meas_t m;
    fill_storage();
    start_pass(32'd0);
    observe(N + 100, -1, -1, m);
    exp_q.delete();
    obs_q.delete();
    checks++; if (m.done_c1 !== 1'b0 || m.busy_c1 !== 1'b1) begin failures++; $display("FAIL zero_start_clears got=d%b/b%b exp=d0/b1", m.done_c1, m.busy_c1); end
    checks++; if (m.rst_low !== 0) begin failures++; $display("FAIL zero_run_len got=%0d exp=0", m.rst_low); end
    checks++; if (m.end_cyc !== N + 4) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=%0d", m.end_cyc, N + 4); end
    checks++; if (m.done_end !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", m.done_end); end
  endtask

  task automatic test_ignored_start();
    meas_t m;
    logic e, o;
    fill_storage();
    start_pass(32'd5);
    observe(N + 100, 100, N + 6, m);
    checks++; if (m.cfg_rst_busy !== 1) begin failures++; $display("FAIL ign_cfg_passes got=%0d exp=1", m.cfg_rst_busy); end
    checks++; if (m.en_cnt !== N) begin failures++; $display("FAIL ign_fab_en_cnt got=%0d exp=%0d", m.en_cnt, N); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin failures++; $display("FAIL ign_bit got=%b exp=%b", o, e); end
    end
    obs_q.delete();
    checks++; if (m.rst_low !== 5) begin failures++; $display("FAIL ign_run_len got=%0d exp=5", m.rst_low); end
    checks++; if (m.end_cyc !== N + 9) begin failures++; $display("FAIL ign_done_cycle got=%0d exp=%0d", m.end_cyc, N + 9); end
    repeat (20) @(negedge clock);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ign_single_done got=d%b/b%b exp=d1/b0", done, busy); end
  endtask

  task automatic test_watchdog();
    meas_t m;
    block_done = 1'b1;
    fill_storage();
    start_pass(32'd7);
    observe(N + 100, -1, -1, m);
    exp_q.delete();
    obs_q.delete();
    checks++; if (m.end_cyc !== N + 2 + TO) begin failures++; $display("FAIL wd_error_cycle got=%0d exp=%0d", m.end_cyc, N + 2 + TO); end
    checks++; if (m.err_end !== 1'b1 || m.done_end !== 1'b0) begin failures++; $display("FAIL wd_flags got=e%b/d%b exp=e1/d0", m.err_end, m.done_end); end
    checks++; if (m.rst_end !== 1'b1 || m.busy_end !== 1'b0 || m.rst_low !== 0) begin failures++; $display("FAIL wd_fabric got=r%b/b%b/low%0d exp=r1/b0/low0", m.rst_end, m.busy_end, m.rst_low); end
    repeat (2) @(negedge clock);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL wd_error_held got=%b exp=1", error); end
    block_done = 1'b0;
    start_pass(32'd3);
    observe(N + 100, -1, -1, m);
    exp_q.delete();
    obs_q.delete();
    checks++; if (m.err_c1 !== 1'b0) begin failures++; $display("FAIL wd_restart_clears got=%b exp=0", m.err_c1); end
    checks++; if (m.end_cyc !== N + 7 || m.done_end !== 1'b1) begin failures++; $display("FAIL wd_restart_done got=c%0d/d%b exp=c%0d/d1", m.end_cyc, m.done_end, N + 7); end
  endtask

  task automatic test_abort();
    meas_t m;
    logic e, o;
    fill_storage();
    start_pass(32'd2);
    repeat (100) @(negedge clock);
    checks++; if (cfg_enable !== 1'b1) begin failures++; $display("FAIL abort_pre_load got=%b exp=1", cfg_enable); end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    exp_q.delete();
    obs_q.delete();
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL abort_state got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (cfg_enable !== 1'b0 || cfg_sync_reset !== 1'b1) begin failures++; $display("FAIL abort_cfg got=en%b/csr%b exp=en0/csr1", cfg_enable, cfg_sync_reset); end
    checks++; if (fabric_config_enable !== 1'b0 || fabric_reset !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_fabric got=en%b/r%b/b%b exp=en0/r1/b0", fabric_config_enable, fabric_reset, busy); end
    fill_storage();
    start_pass(32'd2);
    observe(N + 100, -1, -1, m);
    checks++; if (m.en_cnt !== N) begin failures++; $display("FAIL abort_reload_cnt got=%0d exp=%0d", m.en_cnt, N); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin failures++; $display("FAIL abort_reload_bit got=%b exp=%b", o, e); end
    end
    obs_q.delete();
    checks++; if (m.end_cyc !== N + 6 || m.done_end !== 1'b1) begin failures++; $display("FAIL abort_reload_done got=c%0d/d%b exp=c%0d/d1", m.end_cyc, m.done_end, N + 6); end
  endtask

  task automatic test_reset_mid(input int at_cyc, input logic exp_rst_before, input string tag);
    fill_storage();
    start_pass(32'd50);
    repeat (at_cyc - 1) @(negedge clock);
    checks++; if (fabric_reset !== exp_rst_before || busy !== 1'b1) begin failures++; $display("FAIL %s_pre got=r%b/b%b exp=r%b/b1", tag, fabric_reset, busy, exp_rst_before); end
    sync_reset_n = 1'b0;
    @(negedge clock);
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL %s_state got=%0d exp=%0d", tag, dut.state, IDLE); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL %s_flags got=b%b/d%b/e%b exp=b0/d0/e0", tag, busy, done, error); end
    checks++; if (cfg_sync_reset !== 1'b1 || cfg_enable !== 1'b0) begin failures++; $display("FAIL %s_cfg got=csr%b/en%b exp=csr1/en0", tag, cfg_sync_reset, cfg_enable); end
    checks++; if (fabric_config_enable !== 1'b0 || fabric_bitstream !== 1'b0 || fabric_reset !== 1'b1) begin failures++; $display("FAIL %s_fabric got=en%b/bit%b/r%b exp=en0/bit0/r1", tag, fabric_config_enable, fabric_bitstream, fabric_reset); end
    sync_reset_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_nominal();
    test_zero_run();
    test_ignored_start();
    test_watchdog();
    test_abort();
    test_reset_mid(50, 1'b1, "rst_mid_load");
    test_reset_mid(N + 10, 1'b0, "rst_mid_run");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
